// File: rtl/macpu_bus_ram_responder.sv
// RAM responder for the MACPU external bus window: writes commit at the sampling edge;
// reads hold io_lock high for READ_WAIT cycles, then drive io_data until the CPU moves on.
module macpu_bus_ram_responder #(
  parameter logic [15:0] BASE_ADDR = 16'h1000,
  parameter int          ADDR_BITS = 12,
  parameter int          READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] i_addr,
  input  logic        i_rw,
  inout  wire  [15:0] io_data,
  inout  wire         io_lock
);

  localparam int         DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_LD = 4'(READ_WAIT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [15:0]          mem [DEPTH];
  logic [1:0]           st_q, st_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [15:0]          raddr_q, raddr_d;
  logic [15:0]          rdata_q;
  logic                 hit, rd_req, start, rd_en;
  logic [ADDR_BITS-1:0] rd_idx;

  assign hit    = (i_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign rd_req = hit && !i_rw;

  always_comb begin
    st_d    = st_q;
    wcnt_d  = wcnt_q;
    raddr_d = raddr_q;
    start   = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = raddr_q[ADDR_BITS-1:0];
    case (st_q)
      ST_IDLE: start = rd_req;
      ST_WAIT: begin
        if (!rd_req) begin
          st_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            rd_en = 1'b1;
            st_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (!rd_req) begin
          st_d = ST_IDLE;
        end else if (i_addr != raddr_q) begin
          start = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    // A new read (from IDLE or an address change in DATA) restarts the wait sequence.
    if (start) begin
      raddr_d = i_addr;
      wcnt_d  = WAIT_LD;
      if (READ_WAIT == 0) begin
        rd_en  = 1'b1;
        rd_idx = i_addr[ADDR_BITS-1:0];
        st_d   = ST_DATA;
      end else begin
        st_d = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st_q    <= ST_IDLE;
      wcnt_q  <= 4'd0;
      raddr_q <= 16'd0;
      rdata_q <= 16'd0;
    end else begin
      st_q    <= st_d;
      wcnt_q  <= wcnt_d;
      raddr_q <= raddr_d;
      if (rd_en) rdata_q <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (hit && i_rw) mem[i_addr[ADDR_BITS-1:0]] <= io_data;
  end

  // Drivers follow registered state only, so address decode glitches never reach the bus.
  assign io_data = (st_q == ST_DATA) ? rdata_q : 16'hzzzz;
  assign io_lock = (st_q == ST_WAIT) ? 1'b1 :
                   (st_q == ST_DATA) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_macpu_bus_ram_responder.sv
// Bench for macpu_bus_ram_responder: READ_WAIT = 1, 3 and 0 instances on separate buses,
// driven by a shared CPU-side address/rw/data model.
module tb_macpu_bus_ram_responder;

  localparam logic [1:0] L0 = 2'd0;
  localparam logic [1:0] L1 = 2'd1;
  localparam logic [1:0] LZ = 2'd2;

  typedef struct {
    logic [15:0] addr;
    bit          rw;
    logic [15:0] dat;
    logic [1:0]  el;
    bit          edz;
    logic [15:0] ed;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] addr;
  logic        rw;
  logic        den;
  logic [15:0] dat;

  wire [15:0] b0_dat, b1_dat, b2_dat;
  wire        b0_lck, b1_lck, b2_lck;

  assign b0_dat = den ? dat : 16'hzzzz;
  assign b1_dat = den ? dat : 16'hzzzz;
  assign b2_dat = den ? dat : 16'hzzzz;

  wire z_l0 = (b0_lck === 1'bz);
  wire z_l1 = (b1_lck === 1'bz);
  wire z_l2 = (b2_lck === 1'bz);
  wire z_d0 = (b0_dat === 16'hzzzz);
  wire z_d1 = (b1_dat === 16'hzzzz);
  wire z_d2 = (b2_dat === 16'hzzzz);

  macpu_bus_ram_responder #(.READ_WAIT(1)) u_dut (
    .clk(clk), .n_rst(n_rst), .i_addr(addr), .i_rw(rw), .io_data(b0_dat), .io_lock(b0_lck)
  );
  macpu_bus_ram_responder #(.READ_WAIT(3)) u_dut3 (
    .clk(clk), .n_rst(n_rst), .i_addr(addr), .i_rw(rw), .io_data(b1_dat), .io_lock(b1_lck)
  );
  macpu_bus_ram_responder #(.READ_WAIT(0)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .i_addr(addr), .i_rw(rw), .io_data(b2_dat), .io_lock(b2_lck)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  bit          lz[3], lv[3], dz[3];
  logic [15:0] dv[3];
  vec_t        vt[$];

  task automatic samp();
    lz[0] = z_l0; lv[0] = b0_lck; dz[0] = z_d0; dv[0] = b0_dat;
    lz[1] = z_l1; lv[1] = b1_lck; dz[1] = z_d1; dv[1] = b1_dat;
    lz[2] = z_l2; lv[2] = b2_lck; dz[2] = z_d2; dv[2] = b2_dat;
  endtask

  task automatic chk_lock(input string nm, input int d, input logic [1:0] e);
    bit ok;
    n_chk++;
    if (e == LZ) ok = lz[d];
    else         ok = !lz[d] && (lv[d] == e[0]);
    if (!ok) begin
      n_err++;
      $display("FAIL %s dut%0d lock: got %s want %s", nm, d,
               lz[d] ? "z" : (lv[d] ? "1" : "0"), (e == LZ) ? "z" : (e[0] ? "1" : "0"));
    end
  endtask

  task automatic chk_data(input string nm, input int d, input bit ez, input logic [15:0] e);
    bit ok;
    n_chk++;
    ok = ez ? dz[d] : (!dz[d] && (dv[d] === e));
    if (!ok) begin
      n_err++;
      $display("FAIL %s dut%0d data: got %s want %s", nm, d,
               dz[d] ? "z" : $sformatf("%04h", dv[d]), ez ? "z" : $sformatf("%04h", e));
    end
  endtask

  task automatic drive(input logic [15:0] a, input bit w, input logic [15:0] dt);
    addr = a; rw = w; den = w; dat = dt;
  endtask

  function automatic void add(input logic [15:0] a, input bit w, input logic [15:0] dt,
                              input logic [1:0] el, input bit edz, input logic [15:0] ed);
    vec_t v;
    v.addr = a; v.rw = w; v.dat = dt; v.el = el; v.edz = edz; v.ed = ed;
    vt.push_back(v);
  endfunction

  // On write rows the bus carries the CPU's own data.
  function automatic void wr(input logic [15:0] a, input logic [15:0] dt);
    add(a, 1'b1, dt, LZ, 1'b0, dt);
  endfunction

  function automatic void rd(input logic [15:0] a, input logic [1:0] el, input bit edz,
                             input logic [15:0] ed);
    add(a, 1'b0, 16'h0000, el, edz, ed);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    drive(16'h0080, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    samp();
    for (int d = 0; d < 3; d++) begin
      chk_lock("reset", d, LZ);
      chk_data("reset", d, 1'b1, 16'h0000);
    end
    n_rst = 1'b1;

    wr(16'h1000, 16'hA5A5);
    rd(16'h1000, L1, 1'b1, 16'h0000);
    rd(16'h1000, L0, 1'b0, 16'hA5A5);
    rd(16'h1000, L0, 1'b0, 16'hA5A5);
    rd(16'h0080, LZ, 1'b1, 16'h0000);
    wr(16'h1FFF, 16'h1234);
    wr(16'h2000, 16'hDEAD);
    wr(16'h1004, 16'h0004);
    wr(16'h1005, 16'h0005);
    wr(16'h0FFF, 16'hBEEF);
    rd(16'h1FFF, L1, 1'b1, 16'h0000);
    rd(16'h1FFF, L0, 1'b0, 16'h1234);
    rd(16'h2000, LZ, 1'b1, 16'h0000);
    rd(16'h2000, LZ, 1'b1, 16'h0000);
    rd(16'h0FFF, LZ, 1'b1, 16'h0000);
    rd(16'h1004, L1, 1'b1, 16'h0000);
    rd(16'h1004, L0, 1'b0, 16'h0004);
    rd(16'h1005, L1, 1'b1, 16'h0000);
    rd(16'h1005, L0, 1'b0, 16'h0005);
    rd(16'h1000, L1, 1'b1, 16'h0000);
    rd(16'h1000, L0, 1'b0, 16'hA5A5);
    rd(16'h1010, L1, 1'b1, 16'h0000);
    wr(16'h1010, 16'h7777);
    rd(16'h1010, L1, 1'b1, 16'h0000);
    rd(16'h1010, L0, 1'b0, 16'h7777);
    rd(16'h0080, LZ, 1'b1, 16'h0000);

    foreach (vt[i]) begin
      drive(vt[i].addr, vt[i].rw, vt[i].dat);
      @(negedge clk);
      samp();
      chk_lock($sformatf("vec%0d", i), 0, vt[i].el);
      chk_data($sformatf("vec%0d", i), 0, vt[i].edz, vt[i].ed);
    end

    // READ_WAIT = 3: exactly three lock cycles, then abort-by-write from WAIT.
    drive(16'h1010, 1'b1, 16'h5A5A);
    @(negedge clk);
    drive(16'h1010, 1'b0, 16'h0000);
    repeat (3) begin
      @(negedge clk); samp();
      chk_lock("rw3_wait", 1, L1);
      chk_data("rw3_wait", 1, 1'b1, 16'h0000);
    end
    @(negedge clk); samp();
    chk_lock("rw3_data", 1, L0);
    chk_data("rw3_data", 1, 1'b0, 16'h5A5A);
    drive(16'h1011, 1'b0, 16'h0000);
    @(negedge clk); samp();
    chk_lock("rw3_restart", 1, L1);
    drive(16'h1011, 1'b1, 16'h3C3C);
    @(negedge clk); samp();
    chk_lock("rw3_abort", 1, LZ);
    drive(16'h1011, 1'b0, 16'h0000);
    repeat (3) begin
      @(negedge clk); samp();
      chk_lock("rw3_wait2", 1, L1);
    end
    @(negedge clk); samp();
    chk_lock("rw3_data2", 1, L0);
    chk_data("rw3_data2", 1, 1'b0, 16'h3C3C);

    // ROM window: every responder stays off the bus.
    drive(16'h0080, 1'b0, 16'h0000);
    repeat (3) begin
      @(negedge clk); samp();
      for (int d = 0; d < 3; d++) begin
        chk_lock("rom", d, LZ);
        chk_data("rom", d, 1'b1, 16'h0000);
      end
    end

    // Reset asserted mid-WAIT releases the lines without a clock edge.
    drive(16'h1000, 1'b0, 16'h0000);
    @(negedge clk); samp();
    chk_lock("rst_pre", 0, L1);
    #2 n_rst = 1'b0;
    #1 samp();
    for (int d = 0; d < 2; d++) begin
      chk_lock("rst_async", d, LZ);
      chk_data("rst_async", d, 1'b1, 16'h0000);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk); samp();
    chk_lock("rst_rd_wait", 0, L1);
    chk_data("rst_rd_wait", 0, 1'b1, 16'h0000);
    @(negedge clk); samp();
    chk_lock("rst_rd_data", 0, L0);
    chk_data("rst_rd_data", 0, 1'b0, 16'hA5A5);

    // READ_WAIT = 0: data one cycle after the hit, lock driven low with it.
    drive(16'h0080, 1'b0, 16'h0000);
    @(negedge clk); samp();
    chk_lock("rw0_idle", 2, LZ);
    drive(16'h1004, 1'b0, 16'h0000);
    @(negedge clk); samp();
    chk_lock("rw0_a", 2, L0);
    chk_data("rw0_a", 2, 1'b0, 16'h0004);
    drive(16'h1005, 1'b0, 16'h0000);
    @(negedge clk); samp();
    chk_lock("rw0_b", 2, L0);
    chk_data("rw0_b", 2, 1'b0, 16'h0005);
    drive(16'h0080, 1'b0, 16'h0000);
    @(negedge clk); samp();
    chk_lock("rw0_leave", 2, LZ);
    chk_data("rw0_leave", 2, 1'b1, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
